// File: rtl/sysa_seq_if.sv
// Bundles the command, result and array-side signals of the 3x3 systolic sequencer.
// slave = the sequencer itself, master = the environment (command source, array, result sink).
interface sysa_seq_if #(
  parameter int DW = 8,
  parameter int OW = 16
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_op;
  logic [9*DW-1:0] cmd_data;
  logic            sa_en;
  logic [9*DW-1:0] sa_w;
  logic [3*DW-1:0] sa_in;
  logic [OW-1:0]   sa_out0;
  logic [OW-1:0]   sa_out1;
  logic [OW-1:0]   sa_out2;
  logic            res_valid;
  logic            res_ready;
  logic [9*OW-1:0] res_data;
  logic            busy;
  logic            err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, sa_out0, sa_out1, sa_out2, res_ready,
    output cmd_ready, sa_en, sa_w, sa_in, res_valid, res_data, busy, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, sa_out0, sa_out1, sa_out2, res_ready,
    input  cmd_ready, sa_en, sa_w, sa_in, res_valid, res_data, busy, err
  );
endinterface

// File: rtl/sysa_seq.sv
// Sequencer for a 3x3 weight-stationary systolic array: loads weights, feeds a skewed matrix,
// collects the array outputs into a result matrix; run accept to res_valid is 6+LAT cycles.
module sysa_seq #(
  parameter int LAT = 2,
  parameter int DW  = 8,
  parameter int OW  = 16
) (
  input  logic      clk,
  input  logic      rst,
  sysa_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

  localparam logic [3:0] T_LAST = 4'(4 + LAT);

  state_t          state_q;
  logic [3:0]      t_q;
  logic [3:0]      t_d;
  logic            wloaded_q;
  logic [9*DW-1:0] a_q;
  logic [9*DW-1:0] w_q;
  logic [3*DW-1:0] sa_in_q;
  logic            sa_en_q;
  logic            res_valid_q;
  logic            busy_q;
  logic            err_q;
  logic [9*OW-1:0] res_q;
  logic [9*OW-1:0] res_d;
  logic [OW-1:0]   sa_out [3];
  logic            cmd_fire;

  assign sa_out[0] = bus.sa_out0;
  assign sa_out[1] = bus.sa_out1;
  assign sa_out[2] = bus.sa_out2;

  // Ready is held low while rst is asserted so it reads 1 on the very first cycle after release.
  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign t_d           = t_q + 4'd1;

  assign bus.sa_en     = sa_en_q;
  assign bus.sa_w      = w_q;
  assign bus.sa_in     = sa_in_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

  // Row r of the input matrix enters lane j at step r+j (diagonal wavefront).
  function automatic logic [3*DW-1:0] skew(input logic [9*DW-1:0] m, input logic [3:0] t);
    logic [3*DW-1:0] v;
    int              r;
    v = '0;
    for (int j = 0; j < 3; j++) begin
      r = int'(t) - j;
      if (r >= 0 && r <= 2) v[j*DW +: DW] = m[(r*3+j)*DW +: DW];
    end
    return v;
  endfunction

  // Lane c carries row r's result LAT cycles after that row's element reached lane c.
  always_comb begin
    res_d = res_q;
    for (int c = 0; c < 3; c++) begin
      if (state_q == FEED && int'(t_q) >= c + LAT && int'(t_q) <= c + LAT + 2) begin
        res_d[((int'(t_q) - c - LAT)*3 + c)*OW +: OW] = sa_out[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      wloaded_q   <= 1'b0;
      a_q         <= '0;
      w_q         <= '0;
      sa_in_q     <= '0;
      sa_en_q     <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (!bus.cmd_op) begin
              w_q       <= bus.cmd_data;
              wloaded_q <= 1'b1;
            end else if (!wloaded_q) begin
              err_q <= 1'b1;
            end else begin
              a_q     <= bus.cmd_data;
              t_q     <= '0;
              state_q <= FEED;
              busy_q  <= 1'b1;
              sa_en_q <= 1'b1;
              sa_in_q <= skew(bus.cmd_data, 4'd0);
              res_q   <= '0;
            end
          end
        end
        FEED: begin
          res_q <= res_d;
          if (t_q == T_LAST) begin
            state_q     <= DONE;
            sa_en_q     <= 1'b0;
            sa_in_q     <= '0;
            res_valid_q <= 1'b1;
          end else begin
            t_q     <= t_d;
            sa_in_q <= skew(a_q, t_d);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysa_seq.sv
// Randomized scoreboard bench for sysa_seq; the bench plays both the command source and the
// systolic array, and predicts skewed inputs and captured results from the matrix rules.
module tb_sysa_seq;
  localparam int LAT = 2;
  localparam int DW  = 8;
  localparam int OW  = 16;
  localparam int NT  = 5 + LAT;
  localparam int RW  = 9 * OW;

  typedef struct {
    logic [RW-1:0] res;
    int            acc;
  } res_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sysa_seq_if #(.DW(DW), .OW(OW)) bus ();
  sysa_seq #(.LAT(LAT), .DW(DW), .OW(OW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  res_exp_t        rq[$];
  logic [3*DW-1:0] sq[$];
  logic [9*DW-1:0] w_model;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  initial begin
    logic     prev_rv;
    res_exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.res_valid && !prev_rv) begin
        if (rq.size() == 0) chk("res_unexpected", RW'(1), RW'(0));
        else begin
          e = rq.pop_front();
          chk("res_data", bus.res_data, e.res);
          chk("res_latency", RW'(cyc - e.acc), RW'(6 + LAT));
        end
      end
      prev_rv = bus.res_valid;
      if (bus.sa_en) begin
        if (sq.size() == 0) chk("sa_in_unexpected", RW'(1), RW'(0));
        else chk("sa_in", RW'(bus.sa_in), RW'(sq.pop_front()));
      end else begin
        chk("sa_in_idle", RW'(bus.sa_in), RW'(0));
      end
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, "_cmd_ready"}, RW'(bus.cmd_ready), RW'(0));
    chk({nm, "_sa_en"}, RW'(bus.sa_en), RW'(0));
    chk({nm, "_sa_w"}, RW'(bus.sa_w), RW'(0));
    chk({nm, "_res_data"}, bus.res_data, RW'(0));
    chk({nm, "_res_valid"}, RW'(bus.res_valid), RW'(0));
    chk({nm, "_err"}, RW'(bus.err), RW'(0));
    chk({nm, "_busy"}, RW'(bus.busy), RW'(0));
  endtask

  task automatic do_load(input logic [9*DW-1:0] w);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_data  = w;
    chk("load_ready", RW'(bus.cmd_ready), RW'(1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    w_model = w;
    chk("sa_w_load", RW'(bus.sa_w), RW'(w));
  endtask

  task automatic err_run(input logic [9*DW-1:0] a);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    bus.cmd_data  = a;
    chk("err_run_ready", RW'(bus.cmd_ready), RW'(1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("err_pulse", RW'(bus.err), RW'(1));
    chk("err_busy", RW'(bus.busy), RW'(0));
    chk("err_sa_en", RW'(bus.sa_en), RW'(0));
    @(negedge clk);
    chk("err_one_cycle", RW'(bus.err), RW'(0));
    chk("err_stay_idle", RW'(bus.cmd_ready), RW'(1));
  endtask

  task automatic do_run(input logic [9*DW-1:0] a, input bit rnd, input int hold,
                        input bit abort, output int acc, output int hs);
    logic [OW-1:0]   pat [NT][3];
    logic [RW-1:0]   er;
    logic [3*DW-1:0] v;
    int              n;
    acc = -1;
    hs  = -1;
    er  = '0;
    for (int t = 0; t < NT; t++)
      for (int c = 0; c < 3; c++)
        pat[t][c] = rnd ? OW'($urandom) : OW'(256 * c + t);
    // Result (r,c) is whatever array lane c shows at step r+c+LAT.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        er[(r*3+c)*OW +: OW] = pat[r+c+LAT][c];
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    bus.cmd_data  = a;
    n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("run_accept_timeout", RW'(0), RW'(1));
      bus.cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    for (int t = 0; t < NT; t++) begin
      v = '0;
      for (int j = 0; j < 3; j++)
        if (t - j >= 0 && t - j <= 2) v[j*DW +: DW] = a[((t-j)*3+j)*DW +: DW];
      sq.push_back(v);
    end
    if (!abort) rq.push_back('{er, acc});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int t = 0; t < NT; t++) begin
      bus.sa_out0 = pat[t][0];
      bus.sa_out1 = pat[t][1];
      bus.sa_out2 = pat[t][2];
      chk("busy_feed", RW'(bus.busy), RW'(1));
      chk("ready_feed", RW'(bus.cmd_ready), RW'(0));
      if (t < LAT) chk("res_cleared", bus.res_data, RW'(0));
      if (abort && t == 3) begin
        rst = 1'b1;
        @(negedge clk);
        chk_reset("abort");
        sq.delete();
        w_model = '0;
        rst = 1'b0;
        bus.sa_out0 = '0;
        bus.sa_out1 = '0;
        bus.sa_out2 = '0;
        @(negedge clk);
        chk("ready_after_abort", RW'(bus.cmd_ready), RW'(1));
        return;
      end
      @(negedge clk);
    end
    bus.sa_out0 = '0;
    bus.sa_out1 = '0;
    bus.sa_out2 = '0;
    chk("res_valid_done", RW'(bus.res_valid), RW'(1));
    for (int h = 0; h < hold; h++) begin
      bus.res_ready = 1'b0;
      chk("hold_res_valid", RW'(bus.res_valid), RW'(1));
      chk("hold_res_data", bus.res_data, er);
      chk("hold_cmd_ready", RW'(bus.cmd_ready), RW'(0));
      bus.cmd_valid = (h == hold / 2);
      bus.cmd_op    = 1'b0;
      bus.cmd_data  = ~w_model;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    hs = cyc;
    @(negedge clk);
    chk("ready_after_hs", RW'(bus.cmd_ready), RW'(1));
    chk("res_valid_drop", RW'(bus.res_valid), RW'(0));
    chk("sa_w_kept", RW'(bus.sa_w), RW'(w_model));
  endtask

  initial begin
    logic [9*DW-1:0] w1, a1, ar;
    int acc, hs, acc2, hs2;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b0;
    bus.sa_out0   = '0;
    bus.sa_out1   = '0;
    bus.sa_out2   = '0;
    w_model       = '0;
    for (int i = 0; i < 9; i++) w1[i*DW +: DW] = DW'(i + 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) a1[(r*3+c)*DW +: DW] = DW'(16 * r + c);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", RW'(bus.cmd_ready), RW'(1));

    err_run({9{8'h01}});

    // Back-to-back loads in consecutive cycles, ending on the directed weights.
    do_load(72'($urandom));
    do_load(w1);

    do_run(a1, 1'b0, 10, 1'b0, acc, hs);
    do_run(a1, 1'b1, 0, 1'b1, acc, hs);
    err_run(a1);

    do_load(w1);
    do_run(a1, 1'b1, 0, 1'b0, acc, hs);
    do_run(72'({$urandom, $urandom, $urandom}), 1'b1, 0, 1'b0, acc2, hs2);
    chk("back_to_back_accept", RW'(acc2), RW'(hs + 1));
    chk("back_to_back_sa_w", RW'(bus.sa_w), RW'(w1));

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) do_load(72'({$urandom, $urandom, $urandom}));
      ar = 72'({$urandom, $urandom, $urandom});
      do_run(ar, 1'b1, int'($urandom_range(0, 3)), 1'b0, acc, hs);
    end

    repeat (3) @(negedge clk);
    chk("res_queue_drained", RW'(rq.size()), RW'(0));
    chk("sa_in_queue_drained", RW'(sq.size()), RW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
